// File: rtl/cdc_2phase_pkg.sv
// Shared types for the multi-channel 2-phase CDC destination: channel slot state
// and the channel-index width helper.
package cdc_2phase_pkg;

   typedef enum logic [1:0] {
      CH_EMPTY = 2'd0,
      CH_FULL  = 2'd1,
      CH_WAIT  = 2'd2
   } ch_state_e;

   // A single-channel instance still carries a 1-bit channel index.
   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdc_2phase_mc_dst_if.sv
// Output item stream of the CDC destination: valid/ready handshake with payload
// and source-channel tag.
// Handshake: an item transfers on a clock edge where valid && ready; while valid
// is high and ready low, the producer holds valid, data and ch unchanged.
interface cdc_2phase_mc_dst_if #(
   parameter int DATA_W = 8,
   parameter int CH_W   = 2
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CH_W-1:0]   ch;

   modport master (output valid, output data, output ch, input ready);
   modport slave  (input valid, input data, input ch, output ready);
endinterface

// File: rtl/cdc_2phase_mc_dst_out.sv
// Output register stage: picks one FULL slot per cycle and presents it on the
// item stream, reloading on the same edge as a pop for back-to-back items.
module cdc_2phase_mc_dst_out #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int CH_W   = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_CH-1:0]         full,
   input  logic [DATA_W-1:0]         slots [NUM_CH],
   output logic [NUM_CH-1:0]         grant,
   cdc_2phase_mc_dst_if.master       bus
);

   logic              load;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;

   assign load  = (!bus.valid || bus.ready) && (|full);
   assign grant = load ? gnt : '0;

   prim_rr_arb #(.N(NUM_CH), .W(CH_W)) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (full),
      .adv     (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.valid <= 1'b0;
         bus.data  <= '0;
         bus.ch    <= '0;
      end else if (load) begin
         bus.valid <= 1'b1;
         bus.data  <= slots[gnt_idx];
         bus.ch    <= gnt_idx;
      end else if (bus.ready) begin
         bus.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/prim_rr_arb.sv
// Round-robin arbiter: search starts at the channel after the last accepted grant;
// the pointer moves only when the grant is accepted (adv).
module prim_rr_arb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] idx;
   logic         found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = W'((int'(ptr_q) + i) % N);
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (adv && found) begin
         ptr_q <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
      end
   end

endmodule

// File: rtl/cdc_2phase_mc_dst.sv
// Multi-channel 2-phase CDC destination. The source half must be reset together
// with this block: reset clears ack, so a source left with req toggled would hang.
module cdc_2phase_mc_dst
   import cdc_2phase_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EARLY_ACK   = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_CH-1:0]             async_req_i,
   input  logic [NUM_CH*DATA_W-1:0]      async_data_i,
   output logic [NUM_CH-1:0]             async_ack_o,
   input  logic [NUM_CH-1:0]             ch_en_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [DATA_W-1:0]             data_o,
   output logic [ch_idx_w(NUM_CH)-1:0]   ch_o
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   (* async_reg = "true", dont_touch = "true" *) logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   (* dont_touch = "true" *) logic [DATA_W-1:0] slot_q [NUM_CH];

   ch_state_e         state_q [NUM_CH];
   logic [NUM_CH-1:0] req_s;
   logic [NUM_CH-1:0] ack_q;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] grant;

   cdc_2phase_mc_dst_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

   assign bus.ready   = ready_i;
   assign valid_o     = bus.valid;
   assign data_o      = bus.data;
   assign ch_o        = bus.ch;
   assign async_ack_o = ack_q;
   assign req_s       = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= async_req_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   always_comb begin
      full = '0;
      pop  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c] = (state_q[c] == CH_FULL);
         pop[c]  = bus.valid && ready_i && (bus.ch == CH_W'(c));
      end
   end

   // A pending request stays unacked while its channel is disabled or occupied.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= CH_EMPTY;
            slot_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
               CH_EMPTY: begin
                  if ((req_s[c] != ack_q[c]) && ch_en_i[c]) begin
                     slot_q[c]  <= async_data_i[c*DATA_W +: DATA_W];
                     state_q[c] <= CH_FULL;
                     if (EARLY_ACK != 0) ack_q[c] <= !ack_q[c];
                  end
               end
               CH_FULL: begin
                  if (grant[c]) state_q[c] <= (EARLY_ACK != 0) ? CH_EMPTY : CH_WAIT;
               end
               CH_WAIT: begin
                  if (pop[c]) begin
                     state_q[c] <= CH_EMPTY;
                     ack_q[c]   <= !ack_q[c];
                  end
               end
               default: state_q[c] <= CH_EMPTY;
            endcase
         end
      end
   end

   cdc_2phase_mc_dst_out #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) u_out (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .full   (full),
      .slots  (slot_q),
      .grant  (grant),
      .bus    (bus)
   );

endmodule

// File: tb/tb_cdc_2phase_mc_dst.sv
// Bench for cdc_2phase_mc_dst: one early-ack and one late-ack instance, directed
// steps with a scoreboard on the early-ack output stream.
module tb_cdc_2phase_mc_dst;

   localparam int SS = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req1  = '0;
   logic [3:0]  en1   = '1;
   logic [31:0] data1 = '0;
   logic [3:0]  ack1;
   logic [3:0]  req0  = '0;
   logic [3:0]  en0   = '1;
   logic [31:0] data0 = '0;
   logic [3:0]  ack0;

   logic [9:0]  exp_q [$];
   int          vectors     = 0;
   int          miscompares = 0;

   cdc_2phase_mc_dst_if #(.DATA_W(8), .CH_W(2)) b1 ();
   cdc_2phase_mc_dst_if #(.DATA_W(8), .CH_W(2)) b0 ();

   always #5 clk = ~clk;

   cdc_2phase_mc_dst #(.NUM_CH(4), .DATA_W(8), .SYNC_STAGES(SS), .EARLY_ACK(1)) dut1 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .async_req_i  (req1),
      .async_data_i (data1),
      .async_ack_o  (ack1),
      .ch_en_i      (en1),
      .valid_o      (b1.valid),
      .ready_i      (b1.ready),
      .data_o       (b1.data),
      .ch_o         (b1.ch)
   );

   cdc_2phase_mc_dst #(.NUM_CH(4), .DATA_W(8), .SYNC_STAGES(SS), .EARLY_ACK(0)) dut0 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .async_req_i  (req0),
      .async_data_i (data0),
      .async_ack_o  (ack0),
      .ch_en_i      (en0),
      .valid_o      (b0.valid),
      .ready_i      (b0.ready),
      .data_o       (b0.data),
      .ch_o         (b0.ch)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input int c, input logic [7:0] d);
      data1[c*8 +: 8] = d;
      req1[c]         = !req1[c];
      exp_q.push_back({2'(c), d});
   endtask

   // Scoreboard: every accepted early-ack output item must match the queue head.
   always @(negedge clk) begin
      if (rst_n && b1.valid && b1.ready) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_unexpected: observed ch %0d data %0h expected no item", b1.ch, b1.data);
         end
         if (exp_q.size() != 0) check("sb_item", {22'd0, b1.ch, b1.data}, {22'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] a;
      logic       got;
      b1.ready = 1'b1;
      b0.ready = 1'b1;

      #2;
      check("rst_valid1", b1.valid, 0);
      check("rst_ack1",   ack1,     0);
      check("rst_data1",  b1.data,  0);
      check("rst_ch1",    b1.ch,    0);
      check("rst_valid0", b0.valid, 0);
      check("rst_ack0",   ack0,     0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // single item on ch2, latency and early ack
      a = ack1;
      send1(2, 8'hA5);
      tick();
      check("a_ack_e0", ack1, a);
      tick();
      check("a_ack_e1",   ack1,     a);
      check("a_valid_e1", b1.valid, 0);
      tick();
      check("a_ack_e2",   ack1,     a ^ 4'b0100);
      check("a_valid_e2", b1.valid, 0);
      tick();
      check("a_valid_e3", b1.valid, 1);
      check("a_data_e3",  b1.data,  8'hA5);
      check("a_ch_e3",    b1.ch,    2);
      tick();
      check("a_valid_e4", b1.valid, 0);

      // ch3 so the pointer wraps back to ch0
      send1(3, 8'h77);
      repeat (6) tick();

      // all four channels at once
      for (int c = 0; c < 4; c++) send1(c, 8'(8'h10 + c));
      repeat (3) tick();
      check("c_valid_pre", b1.valid, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("c_valid", b1.valid, 1);
         check("c_ch",    b1.ch,    k);
         check("c_data",  b1.data,  8'h10 + k);
      end
      tick();
      check("c_valid_post", b1.valid, 0);

      // last grant was ch3: ch0 must win over ch3
      send1(0, 8'h21);
      send1(3, 8'h24);
      repeat (4) tick();
      check("d_first_ch", b1.ch, 0);
      tick();
      check("d_second_ch", b1.ch, 3);
      repeat (3) tick();

      // disabled channel keeps its request pending
      en1[1]     = 1'b0;
      a          = ack1;
      data1[15:8] = 8'h5A;
      req1[1]    = !req1[1];
      repeat (6) begin
         tick();
         check("e_blk_ack",   ack1,     a);
         check("e_blk_valid", b1.valid, 0);
      end
      en1[1] = 1'b1;
      exp_q.push_back({2'd1, 8'h5A});
      got = 1'b0;
      for (int i = 0; i < SS + 2 && !got; i++) begin
         tick();
         if (b1.valid) got = 1'b1;
      end
      check("e_within", got,     1);
      check("e_ack",    ack1,    a ^ 4'b0010);
      check("e_ch",     b1.ch,   1);
      check("e_data",   b1.data, 8'h5A);
      repeat (3) tick();

      // late ack: held output under backpressure, ack on the handshake edge
      b0.ready    = 1'b0;
      a           = ack0;
      data0[15:8] = 8'h3C;
      req0[1]     = 1'b1;
      repeat (4) tick();
      check("b_valid", b0.valid, 1);
      check("b_data",  b0.data,  8'h3C);
      check("b_ch",    b0.ch,    1);
      check("b_ack",   ack0,     a);
      repeat (10) begin
         tick();
         check("b_hold_valid", b0.valid, 1);
         check("b_hold_data",  b0.data,  8'h3C);
         check("b_hold_ch",    b0.ch,    1);
         check("b_hold_ack",   ack0,     a);
      end
      b0.ready = 1'b1;
      @(negedge clk);
      check("b_ack_pre", ack0, a);
      tick();
      check("b_ack_post",   ack0,     a ^ 4'b0010);
      check("b_valid_post", b0.valid, 0);

      // reset while an item is stalled on the output
      b1.ready   = 1'b0;
      data1[7:0] = 8'h99;
      req1[0]    = !req1[0];
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         if (b1.valid) got = 1'b1;
      end
      check("f_stalled", got, 1);
      #3;
      rst_n = 1'b0;
      req1  = '0;
      req0  = '0;
      data1 = '0;
      #1;
      check("f_rst_valid", b1.valid, 0);
      check("f_rst_ack",   ack1,     0);
      check("f_rst_data",  b1.data,  0);
      tick(); tick();
      rst_n    = 1'b1;
      b1.ready = 1'b1;
      tick();
      send1(1, 8'h42);
      repeat (4) tick();
      check("f_after_valid", b1.valid, 1);
      check("f_after_ch",    b1.ch,    1);
      check("f_after_data",  b1.data,  8'h42);
      check("f_after_ack",   ack1,     4'b0010);
      repeat (3) tick();

      check("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cdc_2phase_mc_dst.md
CDC_2PHASE_MC_DST -- requirements
Module: cdc_2phase_mc_dst

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent 2-phase input channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the payload width per channel.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the request synchronizer depth (2..4).
REQ-004 SHALL have parameter EARLY_ACK, default 1, meaning: 1 = ack on capture into the local slot; 0 = ack on output handshake.
REQ-005 SHALL have port clk_i, input, 1 bit: clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port async_req_i, input, NUM_CH bits: per-channel request toggle, asynchronous to clk_i.
REQ-008 SHALL have port async_data_i, input, NUM_CH*DATA_W bits: per-channel payload; channel c occupies bits [c*DATA_W +: DATA_W]; stable while req differs from ack.
REQ-009 SHALL have port async_ack_o, output, NUM_CH bits: per-channel acknowledge toggle.
REQ-010 SHALL have port ch_en_i, input, NUM_CH bits: per-channel capture enable.
REQ-011 SHALL have port valid_o, input/output direction output, 1 bit: output item valid.
REQ-012 SHALL have port ready_i, input, 1 bit: downstream ready.
REQ-013 SHALL have port data_o, output, DATA_W bits: output payload.
REQ-014 SHALL have port ch_o, output, clog2(NUM_CH) bits (min 1): source channel of data_o.

Function
REQ-015 Each async_req_i bit SHALL pass through SYNC_STAGES flops, all reset to 0; downstream logic SHALL use only the last stage, req_s[c].
REQ-016 Each channel SHALL have a state machine: EMPTY, FULL, WAIT; WAIT is reachable only when EARLY_ACK=0.
REQ-017 In EMPTY, with req_s[c] != ack_q[c] and ch_en_i[c]=1, the channel SHALL latch async_data_i slice into its slot and go to FULL on that edge.
REQ-018 With EARLY_ACK=1, ack_q[c] SHALL toggle on the capture edge.
REQ-019 With EARLY_ACK=1, FULL SHALL go to EMPTY when the slot is granted.
REQ-020 With EARLY_ACK=0, FULL SHALL go to WAIT when granted.
REQ-021 With EARLY_ACK=0, WAIT SHALL go to EMPTY and toggle ack_q[c] on the edge where valid_o && ready_i && ch_o==c.
REQ-022 The output register SHALL load when (!valid_o || ready_i) and at least one slot is FULL.
REQ-023 Grant SHALL be round-robin, starting at the channel after the last granted one.
REQ-024 Pop and load on the same edge SHALL be allowed, giving 1 item/cycle sustained throughput.
REQ-025 While valid_o=1 and ready_i=0, data_o and ch_o SHALL hold stable and valid_o SHALL remain 1.
REQ-026 Latency, single item, no contention, ready_i=1: async_req_i toggle before edge 0 -> slot FULL after edge SYNC_STAGES -> valid_o=1 after edge SYNC_STAGES+1.
REQ-027 Deasserting ch_en_i[c] SHALL block new captures only; a FULL/WAIT item SHALL still drain, and a pending request SHALL remain unacked.
REQ-028 Simultaneous requests on all channels SHALL each be output exactly once, in round-robin order, with none lost or duplicated.
REQ-029 async_ack_o SHALL be driven directly from ack_q flops, with no combinational logic.

Reset
REQ-030 On rst_ni low, all synchronizer flops, ack_q, slots, valid_o, data_o, ch_o and the round-robin pointer SHALL clear to 0 asynchronously; channel 0 SHALL have first priority after reset; all channels SHALL be EMPTY.
REQ-031 Reset mid-transfer SHALL discard slot and output contents; the source half SHALL be reset together with this block, and this SHALL be a documented integration rule.

Structure
REQ-032 Package cdc_2phase_pkg SHALL hold the channel state enum (EMPTY/FULL/WAIT) and the channel-index width function.
REQ-033 The round-robin grant SHALL be a sub-module prim_rr_arb (NUM_CH request/grant, advance on grant accepted).
REQ-034 Synchronizer and data flops SHALL carry async_reg/dont_touch attributes.

Verification
REQ-035 The bench SHALL cover: EARLY_ACK=1, toggle ch2 req with data 0xA5, ready_i=1 -> async_ack_o[2] toggles 2 cycles after sync; valid_o=1 with data_o=0xA5, ch_o=2 after SYNC_STAGES+1 cycles.
REQ-036 The bench SHALL cover: EARLY_ACK=0, ch1 data 0x3C, ready_i=0 for 10 cycles -> outputs held, ack_o[1] unchanged until the ready_i=1 handshake edge, then toggled.
REQ-037 The bench SHALL cover: all 4 channels toggle in the same cycle with data 0x10..0x13, ready_i=1 -> four consecutive output cycles with ch_o order 0,1,2,3 and correct data.
REQ-038 The bench SHALL cover: last grant ch3, new requests on ch0 and ch3 -> ch0 served first.
REQ-039 The bench SHALL cover: ch_en_i[1]=0 with ch1 req pending -> no ack and no output; after ch_en_i[1]=1 -> captured and output within SYNC_STAGES+2 cycles.
REQ-040 The bench SHALL cover: rst_ni asserted while valid_o=1 and ready_i=0 -> valid_o=0 and async_ack_o=0 immediately, then the next transfer completes normally after release.
